// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: machine width, the canonical NOP
// encoding used for faulting fetches, fetch-responder FSM states and the
// fetch response payload.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic            fault;
   } fetch_resp_t;

endpackage : riscv_pkg

// File: rtl/instr_mem_array.sv
// Single-clock instruction word RAM with one synchronous read port and one
// write port. A read and a write to the same word on the same edge return
// the old contents. Contents are never reset.
//
// Ports:
//   clk      clock
//   rd_en    capture mem[rd_idx] into rd_data on this edge
//   rd_idx   word index to read
//   rd_data  registered read data, held until the next rd_en
//   wr_en    write strobe
//   wr_idx   word index to write
//   wr_data  word to write
module instr_mem_array
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           rd_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
   output logic [XLEN-1:0]                rd_data,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
   input  logic [XLEN-1:0]                wr_data
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   // Write and read in one block: the read samples the pre-edge contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule : instr_mem_array

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder at the memory side of the fetch interface.
// Accepts one fetch at a time, returns the instruction LATENCY edges after
// acceptance, flags misaligned / out-of-range fetches with a NOP payload,
// supports program loading through a side write port, and drops in-flight
// fetches on flush.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      fetch request handshake (req_ready combinational)
//   req_addr                 fetch byte address (PC)
//   resp_valid/resp_ready    response handshake
//   resp_instr, resp_fault   response payload (registered)
//   flush                    drop outstanding work, block acceptance this cycle
//   wr_en, wr_addr, wr_data  program-load write port (word-granular)
//
// DEPTH_WORDS must be a power of two and at least 2; LATENCY must be >= 1.
module instr_mem_responder
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_instr,
   output logic            resp_fault,
   input  logic            flush,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(LATENCY) + 1;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            enter_resp;
   logic            accept;
   logic            req_fault;
   logic            fault_q;
   logic            wr_in_range;
   logic [XLEN-1:0] rd_data;
   fetch_resp_t     resp_q;

   // Combinational ready: flush and reset both block acceptance.
   assign req_ready = !rst && !flush &&
                      ((state == IDLE) || ((state == RESP) && resp_ready));
   assign accept    = req_valid && req_ready;

   // Word index >= DEPTH_WORDS means any byte-address bit above the index is set.
   assign req_fault   = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != '0);
   assign wr_in_range = ((wr_addr >> (AW + 2)) == '0);

   // Faulting fetches never touch the array.
   instr_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_mem (
      .clk     (clk),
      .rd_en   (accept && !req_fault),
      .rd_idx  (req_addr[AW+1:2]),
      .rd_data (rd_data),
      .wr_en   (wr_en && wr_in_range),
      .wr_idx  (wr_addr[AW+1:2]),
      .wr_data (wr_data)
   );

   // State and latency counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      enter_resp = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state_nxt = WAIT;
                  cnt_nxt   = CW'(LATENCY - 1);
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  cnt_nxt = cnt - CW'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  if (accept) begin
                     state_nxt = WAIT;
                     cnt_nxt   = CW'(LATENCY - 1);
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Fault flag and response payload registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q    <= 1'b0;
         resp_valid <= 1'b0;
         resp_q     <= '0;
      end else begin
         if (accept) begin
            fault_q <= req_fault;
         end
         resp_valid <= !flush && (state_nxt == RESP);
         if (enter_resp) begin
            resp_q.instr <= fault_q ? INSTR_NOP : rd_data;
            resp_q.fault <= fault_q;
         end
      end
   end

   assign resp_instr = resp_q.instr;
   assign resp_fault = resp_q.fault;

endmodule : instr_mem_responder

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        resp_ready;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   logic        req_ready,  resp_valid,  resp_fault;
   logic [31:0] resp_instr;
   logic        req_ready4, resp_valid4, resp_fault4;
   logic [31:0] resp_instr4;

   typedef struct {
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [1024];

   always #5 clk = ~clk;

   instr_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_instr(resp_instr), .resp_fault(resp_fault), .flush(flush),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   instr_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
      .req_addr(req_addr), .resp_valid(resp_valid4), .resp_ready(resp_ready),
      .resp_instr(resp_instr4), .resp_fault(resp_fault4), .flush(flush),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   // Scoreboard: every delivered response (handshake on the coming edge) is
   // compared with the oldest expectation.
   always @(negedge clk) begin
      if (!rst && !flush && resp_valid && resp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got instr=%08h fault=%0b with nothing outstanding",
                     resp_instr, resp_fault);
         end else begin
            mon_e = exp_q.pop_front();
            if (resp_instr !== mon_e.instr || resp_fault !== mon_e.fault) begin
               errors++;
               $display("FAIL resp_payload: got instr=%08h fault=%0b, need instr=%08h fault=%0b",
                        resp_instr, resp_fault, mon_e.instr, mon_e.fault);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t expect_for(input logic [31:0] a);
      exp_t e;
      if (a[1:0] != 2'b00 || (a >> 12) != 0) begin
         e.instr = 32'h0000_0013;
         e.fault = 1'b1;
      end else begin
         e.instr = ref_mem[a[11:2]];
         e.fault = 1'b0;
      end
      return e;
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      if ((a >> 12) == 0) ref_mem[a[11:2]] = d;
   endtask

   // Drives a request, records its expectation, and returns 1ns after the
   // acceptance edge with req_valid dropped.
   task automatic issue(input logic [31:0] a);
      int n = 0;
      req_valid = 1'b1; req_addr = a;
      #1;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: addr %08h req_ready=%b after %0d cycles, need 1", a, req_ready, n);
      end
      exp_q.push_back(expect_for(a));
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL resp_timeout: %0d responses outstanding after %0d cycles, need 0", exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL valid_timeout: resp_valid=%b after %0d cycles, need 1", resp_valid, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks += 5;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b need 0", resp_valid); end
      if (resp_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %08h need 00000000", resp_instr); end
      if (resp_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b need 0", resp_fault); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b need 0", req_ready); end
      if (resp_valid4 !== 1'b0) begin errors++; $display("FAIL rst_valid4: got %b need 0", resp_valid4); end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b need 1", req_ready); end
   endtask

   task automatic test_basic();
      do_write(32'h10, 32'hDEAD_BEEF);
      issue(32'h10);                              // now 1ns after t0
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL lat_t0: resp_valid=%b need 0", resp_valid); end
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL lat_t1: resp_valid=%b need 0", resp_valid); end
      tick();
      checks += 3;
      if (resp_valid !== 1'b1) begin errors++; $display("FAIL lat_t2: resp_valid=%b need 1", resp_valid); end
      if (resp_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat_instr: got %08h need deadbeef", resp_instr); end
      if (resp_fault !== 1'b0) begin errors++; $display("FAIL lat_fault: got %b need 0", resp_fault); end
      tick();
      checks += 2;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL lat_t3: resp_valid=%b need 0", resp_valid); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL lat_consumed: %0d outstanding need 0", exp_q.size()); end
   endtask

   task automatic test_fault();
      issue(32'h12);
      wait_resp();
      issue(32'h1000);
      wait_resp();
      do_write(32'h1010, 32'hBAD0_BAD0);          // out of range, aliases word 4 if not dropped
      issue(32'h10);
      wait_resp();
      do_write(32'hFFC, 32'hCAFE_F00D);           // last in-range word
      issue(32'hFFC);
      wait_resp();
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      do_write(32'h30, 32'h1234_5678);
      resp_ready = 1'b0;
      issue(32'h30);
      wait_valid();
      held = resp_instr;
      req_valid = 1'b1; req_addr = 32'h10;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks += 3;
         if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b need 1", i, resp_valid); end
         if (resp_instr !== 32'h1234_5678 || resp_instr !== held) begin
            errors++; $display("FAIL bp_instr[%0d]: got %08h need 12345678", i, resp_instr);
         end
         if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b need 0", i, req_ready); end
      end
      resp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b need 1", req_ready); end
      exp_q.push_back(expect_for(32'h10));
      tick();
      req_valid = 1'b0;
      checks += 2;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_wait: resp_valid=%b need 0", resp_valid); end
      if (exp_q.size() != 1) begin errors++; $display("FAIL b2b_q: %0d outstanding need 1", exp_q.size()); end
      wait_resp();
   endtask

   task automatic test_flush_wait();
      resp_ready = 1'b1;
      issue(32'h10);                              // in WAIT
      flush = 1'b1; req_valid = 1'b1; req_addr = 32'h30;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL fw_ready: got %b need 0", req_ready); end
      exp_q.delete();
      tick();
      flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      #1;
      checks += 2;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL fw_idle: req_ready=%b need 1", req_ready); end
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL fw_valid: got %b need 0", resp_valid); end
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL fw_late: resp_valid=%b need 0", resp_valid); end
   endtask

   task automatic test_flush_resp();
      resp_ready = 1'b0;
      issue(32'h10);
      wait_valid();
      resp_ready = 1'b1; flush = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL fr_ready: got %b need 0", req_ready); end
      exp_q.delete();
      tick();
      flush = 1'b0; resp_ready = 1'b0;
      #1;
      checks += 2;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL fr_valid: got %b need 0", resp_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL fr_idle: req_ready=%b need 1", req_ready); end
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_same_edge();
      exp_t e;
      do_write(32'h20, 32'h1111_1111);
      wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hA5A5_0F0F;
      req_valid = 1'b1; req_addr = 32'h20;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL se_ready: got %b need 1", req_ready); end
      e.instr = 32'h1111_1111;
      e.fault = 1'b0;
      exp_q.push_back(e);
      tick();
      wr_en = 1'b0; req_valid = 1'b0;
      ref_mem[8] = 32'hA5A5_0F0F;
      wait_resp();
      issue(32'h20);
      wait_resp();
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      resp_ready = 1'b1;
      issue(32'h10);
      wait_resp();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (resp_instr4 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rm_pre: lat4 instr=%08h need deadbeef", resp_instr4); end
      issue(32'h10);
      tick();                                     // LATENCY=4 instance mid-WAIT
      rst = 1'b1;
      exp_q.delete();
      #1;
      checks++;
      if (req_ready4 !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b need 0", req_ready4); end
      tick();
      checks += 4;
      if (resp_valid4 !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b need 0", resp_valid4); end
      if (resp_instr4 !== 32'h0) begin errors++; $display("FAIL rm_instr: got %08h need 00000000", resp_instr4); end
      if (resp_fault4 !== 1'b0) begin errors++; $display("FAIL rm_fault: got %b need 0", resp_fault4); end
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_valid2: got %b need 0", resp_valid); end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (resp_valid4 !== 1'b0) begin errors++; $display("FAIL rm_late[%0d]: resp_valid=%b need 0", i, resp_valid4); end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
      flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      test_reset();
      test_basic();
      test_fault();
      test_backpressure();
      test_flush_wait();
      test_flush_resp();
      test_same_edge();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_instr_mem_responder

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-memory responder for the RISC-V five-stage pipeline: the memory-side end of the fetch interface driven by the program counter. Accepts one fetch request at a time over a valid/ready handshake, returns the 32-bit instruction after a fixed, parameterised latency, and reports misaligned or out-of-range fetches. A side write port loads program images, and a flush input discards in-flight fetches on branch redirects.

## Interface
- DEPTH_WORDS, 1024: memory depth in 32-bit words; power of two.
- LATENCY, 2: edges from request acceptance to response visible; must be ≥1.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept this cycle.
- req_addr  input  32  byte address of the fetch, i.e. the PC.
- resp_valid  output  1  response present.
- resp_ready  input  1  fetch stage consumes the response.
- resp_instr  output  32  instruction word.
- resp_fault  output  1  fetch was misaligned or out of range.
- flush  input  1  drop any outstanding or pending response.
- wr_en  input  1  program-load write strobe.
- wr_addr  input  32  byte address of the write; bits [1:0] ignored.
- wr_data  input  32  word to write.

## Operation
- States: IDLE, WAIT, RESP.
- req_ready = !rst && !flush && (IDLE || (RESP && resp_ready)). This is combinational.
- Acceptance happens on an edge with req_valid && req_ready:
  - Latch the fault flag: req_addr[1:0]!=0, or word index req_addr[31:2] ≥ DEPTH_WORDS.
  - Latch the read data, captured at this edge.
  - Load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each edge. When the counter is 0 at an edge, go to RESP.
- RESP: hold resp_valid=1, resp_instr and resp_fault stable until resp_ready.
  - Handshake without a new request: go to IDLE.
  - Handshake with a new request: accept it and go to WAIT.
- Faulting fetch: resp_instr=32'h0000_0013 (NOP), resp_fault=1. Memory is not read.
- flush has priority over everything except rst:
  - From WAIT or RESP, go to IDLE and drop the response.
  - resp_valid=0 on the next cycle.
  - No request is accepted in the flush cycle.
- Write port:
  - wr_en writes wr_data to word wr_addr[31:2] if that index is in range. Out-of-range writes are silently dropped.
  - Writes are independent of the FSM.
  - A write and an acceptance to the same word on the same edge: the response returns the old data.
- Counter width is $clog2(LATENCY)+1. No wrap beyond LATENCY-1.

## Timing
- Reset values: state IDLE, resp_valid=0, resp_instr=0, resp_fault=0, counter=0. req_ready=0 while rst is high. Memory contents are not reset.
- Latency: request accepted at edge t0, resp_valid high in the cycle after edge t0+LATENCY.
- Throughput: one fetch per LATENCY+1 cycles with resp_ready held high.
- Backpressure: resp_valid stays high and the data stays stable for any number of cycles with resp_ready=0.
- Reset mid-operation (WAIT or RESP): outputs return to reset values after the edge, and the outstanding response is lost.
- flush together with resp_ready in RESP: the response counts as dropped, not consumed.
- Simultaneous flush and req_valid: the request is not accepted. The requester must hold or redrive it.

## Structure
- riscv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, and the state enum (IDLE/WAIT/RESP).
- Sub-module instr_mem_array:
  - Single-clock word RAM.
  - One synchronous read port, enabled on acceptance.
  - One write port.
  - Parameter DEPTH_WORDS.
- The responder holds the FSM, counter, fault check and output registers.

## Test plan
- Reset, then write 32'hDEADBEEF to address 0x10 and request 0x10 with LATENCY=2 → resp_valid high after edge t0+2, instr=DEADBEEF, fault=0.
- Request 0x12 (misaligned), then 0x1000 with DEPTH_WORDS=1024 → both return instr=00000013, fault=1.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and data stable, req_ready=0. Release → a back-to-back request is accepted on the handshake edge.
- Assert flush during WAIT, and separately in RESP with resp_ready=1 → no response delivered, state IDLE, req_ready=0 in the flush cycle.
- Write 0x20 := A and request 0x20 on the same edge → response returns the old word. A later request returns A.
- Assert rst during WAIT with LATENCY=4 → resp_valid never rises, and all outputs return to reset values after the edge.
